// File: rtl/tt_bus_mux_bridge.sv
// tt_bus_mux_bridge: serialises CPU bus accesses onto an 8-bit pin lane (address bytes LSB first, then a data phase with ready/timeout).
// Optional TT_BUS_ADDR_SKIP_EN: resend only address byte 0 when the high bytes match the last completed access.
module tt_bus_mux_bridge #(
  parameter int ADDR_W   = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_busy,
  output logic              cpu_timeout,
  output logic [7:0]        pin_byte,
  output logic [1:0]        pin_phase,
  output logic              pin_first,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [7:0]        data_oe,
  input  logic              ext_rdy
);
  localparam int NB = (ADDR_W + 7) / 8;
  localparam int AW = NB * 8;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t          state_q, state_d;
  logic            rw_q, rw_d, to_q, to_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d, rdata_q, rdata_d, cnt_q, cnt_d;
  logic [1:0]      k_q, k_d, last_q, last_d;
  logic            skip;
`ifdef TT_BUS_ADDR_SKIP_EN
  logic [AW-1:0]   hi_q, hi_d;
  logic            hv_q, hv_d;
  assign skip = hv_q && ((AW'(cpu_addr) >> 8) == hi_q);
`else
  assign skip = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    to_d    = to_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    last_d  = last_q;
`ifdef TT_BUS_ADDR_SKIP_EN
    hi_d    = hi_q;
    hv_d    = hv_q;
`endif
    case (state_q)
      IDLE: if (cpu_req) begin
        state_d = ADDR;
        rw_d    = cpu_rw;
        addr_d  = AW'(cpu_addr);
        wdata_d = cpu_wdata;
        k_d     = 2'd0;
        last_d  = skip ? 2'd0 : 2'(NB - 1);
        to_d    = 1'b0;
      end
      ADDR: begin
        k_d     = k_q + 2'd1;
        state_d = (k_q == last_q) ? DATA : ADDR;
        cnt_d   = 8'd0;
      end
      DATA: if (ext_rdy || cnt_q == 8'(WAIT_MAX - 1)) begin
        // ready wins over a timeout landing in the same cycle
        state_d = DONE;
        to_d    = !ext_rdy;
        rdata_d = !rw_q ? rdata_q : ext_rdy ? data_in : 8'hFF;
`ifdef TT_BUS_ADDR_SKIP_EN
        hi_d    = addr_q >> 8;
        hv_d    = ext_rdy;
`endif
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      to_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      cnt_q   <= 8'd0;
      k_q     <= 2'd0;
      last_q  <= 2'd0;
`ifdef TT_BUS_ADDR_SKIP_EN
      hi_q    <= '0;
      hv_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      to_q    <= to_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      last_q  <= last_d;
`ifdef TT_BUS_ADDR_SKIP_EN
      hi_q    <= hi_d;
      hv_q    <= hv_d;
`endif
    end
  end
  logic wr_data;
  assign wr_data     = (state_q == DATA) && !rw_q;
  assign cpu_rdata   = rdata_q;
  assign cpu_busy    = state_q != IDLE;
  assign cpu_done    = state_q == DONE;
  assign cpu_timeout = (state_q == DONE) && to_q;
  assign pin_phase   = state_q == ADDR ? 2'b01 : state_q == DATA ? {1'b1, rw_q} : 2'b00;
  assign pin_first   = (state_q == ADDR) && (k_q == 2'd0);
  assign pin_byte    = state_q == ADDR ? 8'(addr_q >> {k_q, 3'b000}) : wr_data ? wdata_q : 8'd0;
  assign data_out    = wr_data ? wdata_q : 8'd0;
  assign data_oe     = wr_data ? 8'hFF : 8'h00;
endmodule
